// File: rtl/writeback_stage_pkg.sv
// writeback_stage_pkg: shared RISC-V result-select encodings, load funct3 codes and MEM/WB record
package writeback_stage_pkg;
    typedef enum logic [1:0] {
        RES_ALU     = 2'b00,
        RES_LOAD    = 2'b01,
        RES_PC4     = 2'b10,
        RES_ALU_ALT = 2'b11
    } result_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic [4:0]  rd;
        result_src_e result_src;
        logic [31:0] alu_result;
        logic [31:0] pc_plus4;
        logic [2:0]  funct3;
    } memwb_t;
endpackage

// File: rtl/writeback_stage_load_extend.sv
// load_extend: selects and extends the loaded byte/halfword/word from a memory word
//   word   : raw 32-bit data-memory word
//   addr   : low address bits of the load (byte lane)
//   funct3 : load type
//   data   : extended load result
module load_extend
    import writeback_stage_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // addr[0] is deliberately ignored for halfwords: no misalignment trap exists
    always_comb begin
        byte_v = 8'(word >> {addr, 3'b000});
        half_v = addr[1] ? word[31:16] : word[15:0];
        data   = funct3 == F3_LB  ? {{24{byte_v[7]}}, byte_v} :
                 funct3 == F3_LBU ? {24'b0, byte_v} :
                 funct3 == F3_LH  ? {{16{half_v[15]}}, half_v} :
                 funct3 == F3_LHU ? {16'b0, half_v} : word;
    end
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register, result mux, register-file bypass and instret counter
//   clock, reset (async active-low)       : clocking
//   memWbStall, memWbFlush                : MEM/WB hold / bubble insert (flush wins)
//   in*                                   : MEM-stage instruction fields
//   memReadData                           : data-memory word for the load in WB
//   rd, writeData, registerWrite          : register-file write port
//   decodeRs1/2, rfData1/2, bypassData1/2 : decode read ports with the WB write forwarded
//   wbValid, retire, instret              : WB occupancy, retirement pulse, retired count
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            memWbStall,
    input  logic            memWbFlush,
    input  logic            inValid,
    input  logic            inRegisterWrite,
    input  logic [4:0]      inRd,
    input  logic [1:0]      inResultSrc,
    input  logic [XLEN-1:0] inAluResult,
    input  logic [XLEN-1:0] inPcPlus4,
    input  logic [2:0]      inLoadFunct3,
    input  logic [XLEN-1:0] memReadData,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] writeData,
    output logic            registerWrite,
    input  logic [4:0]      decodeRs1,
    input  logic [4:0]      decodeRs2,
    input  logic [XLEN-1:0] rfData1,
    input  logic [XLEN-1:0] rfData2,
    output logic [XLEN-1:0] bypassData1,
    output logic [XLEN-1:0] bypassData2,
    output logic            wbValid,
    output logic            retire,
    output logic [63:0]     instret
);
    if (XLEN != 32) begin : g_xlen_check
        $error("writeback_stage supports XLEN=32 only");
    end

    memwb_t      memwb_q, memwb_d;
    logic [63:0] instret_q, instret_d;
    logic [31:0] load_data;

    load_extend u_load_extend (
        .word   (memReadData),
        .addr   (memwb_q.alu_result[1:0]),
        .funct3 (memwb_q.funct3),
        .data   (load_data)
    );

    always_comb begin
        memwb_d = (memWbStall && !memWbFlush) ? memwb_q : '{
            valid:      inValid,
            reg_write:  inRegisterWrite,
            rd:         inRd,
            result_src: result_src_e'(inResultSrc),
            alu_result: inAluResult,
            pc_plus4:   inPcPlus4,
            funct3:     inLoadFunct3
        };
        // A bubble only needs its valid and write-enable cleared
        if (memWbFlush) begin
            memwb_d.valid     = 1'b0;
            memwb_d.reg_write = 1'b0;
        end
        instret_d = instret_q + 64'(retire);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            memwb_q   <= '0;
            instret_q <= '0;
        end else begin
            memwb_q   <= memwb_d;
            instret_q <= instret_d;
        end
    end

    // A stalled instruction keeps writing (idempotent) but retires only when it leaves
    assign rd            = memwb_q.rd;
    assign wbValid       = memwb_q.valid;
    assign retire        = memwb_q.valid && !memWbStall;
    assign registerWrite = memwb_q.valid && memwb_q.reg_write && (memwb_q.rd != 5'd0);
    assign writeData     = memwb_q.result_src == RES_LOAD ? load_data :
                           memwb_q.result_src == RES_PC4  ? memwb_q.pc_plus4 : memwb_q.alu_result;
    assign bypassData1   = (registerWrite && decodeRs1 == memwb_q.rd) ? writeData : rfData1;
    assign bypassData2   = (registerWrite && decodeRs2 == memwb_q.rd) ? writeData : rfData2;
    assign instret       = instret_q;
endmodule
